// File: rtl/uno_pkg.sv
// Shared UNO card types, constants and the play-legality rule.
// Imported by the hand store and the game controller.
package uno_pkg;

   typedef struct packed {
      logic [1:0] color;
      logic [3:0] value;
   } card_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_GAP
   } hand_state_t;

   localparam logic [1:0] RED    = 2'd0;
   localparam logic [1:0] YELLOW = 2'd1;
   localparam logic [1:0] GREEN  = 2'd2;
   localparam logic [1:0] BLUE   = 2'd3;

   localparam logic [3:0] SKIP    = 4'd10;
   localparam logic [3:0] REVERSE = 4'd11;
   localparam logic [3:0] DRAW2   = 4'd12;
   localparam logic [3:0] WILD    = 4'd13;
   localparam logic [3:0] WILD4   = 4'd14;

   localparam logic [2:0] DRAW1   = 3'b001;
   localparam logic [2:0] DRAW2_C = 3'b010;
   localparam logic [2:0] DRAW4_C = 3'b100;

   function automatic logic card_playable(card_t c, card_t top);
      return (c.color == top.color) ||
             (c.value == top.value) ||
             (c.value == WILD) ||
             (c.value == WILD4);
   endfunction

endpackage

// File: rtl/player_hand_if.sv
// Draw handshake between the deck block and a player hand.
// The hand is master: it raises the draw code, the deck answers.
interface player_hand_if;
   logic       deck_done;
   logic       deck_drawn;
   logic [5:0] deck_card;
   logic [2:0] deck_draw;

   modport master (
      input  deck_done,
      input  deck_drawn,
      input  deck_card,
      output deck_draw
   );

   modport slave (
      output deck_done,
      output deck_drawn,
      output deck_card,
      input  deck_draw
   );
endinterface

// File: rtl/player_hand.sv
// Per-player hand store: fetches cards from the deck, keeps a
// compacted slot array with a cursor and removes legal plays.
module player_hand
   import uno_pkg::*;
#(
   parameter int MAX_CARDS = 16,
   parameter int DEAL_CNT  = 7,
   parameter int CNT_W     = $clog2(MAX_CARDS + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   player_hand_if.master    deck,
   input  logic             i_deal,
   input  logic [2:0]       i_draw_req,
   input  logic             i_cursor_next,
   input  logic             i_cursor_prev,
   input  logic             i_play,
   input  logic [5:0]       i_top_card,
   output logic             o_insert,
   output logic [5:0]       o_play_card,
   output logic             o_illegal,
   output logic [5:0]       o_cursor_card,
   output logic [CNT_W-1:0] o_count,
   output logic [CNT_W-1:0] o_cursor,
   output logic             o_busy,
   output logic             o_empty
);

   localparam int IDX_W = $clog2(MAX_CARDS);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(MAX_CARDS);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   hand_state_t      state_q, state_d;
   logic [2:0]       pend_q, pend_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] cursor_q, cursor_d;
   card_t            slot_q [MAX_CARDS];
   card_t            slot_d [MAX_CARDS];
   card_t            play_q, play_d;
   logic             insert_q, insert_d;
   logic             illegal_q, illegal_d;
   logic             empty_q, empty_d;
   logic             busy_q;
   logic [2:0]       draw_q;

   card_t            cur_card;
   logic [CNT_W-1:0] last;
   logic [2:0]       draw_n;
   logic             nxt_only;
   logic             prv_only;

   assign cur_card = slot_q[cursor_q[IDX_W-1:0]];
   assign last     = count_q - ONE;
   assign nxt_only = i_cursor_next & ~i_cursor_prev;
   assign prv_only = i_cursor_prev & ~i_cursor_next;

   always_comb begin
      draw_n = '0;
      unique case (i_draw_req)
         DRAW1:   draw_n = 3'd1;
         DRAW2_C: draw_n = 3'd2;
         DRAW4_C: draw_n = 3'd4;
         default: draw_n = '0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      pend_d    = pend_q;
      count_d   = count_q;
      cursor_d  = cursor_q;
      slot_d    = slot_q;
      play_d    = play_q;
      empty_d   = empty_q;
      insert_d  = 1'b0;
      illegal_d = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (i_deal) begin
               count_d  = '0;
               cursor_d = '0;
               empty_d  = 1'b0;
               pend_d   = 3'(DEAL_CNT);
               state_d  = S_REQ;
            end else if (draw_n != 3'd0) begin
               pend_d  = draw_n;
               state_d = S_REQ;
            end else if (i_play) begin
               if (count_q != '0 &&
                   card_playable(cur_card, i_top_card)) begin
                  insert_d = 1'b1;
                  play_d   = cur_card;
                  // close the gap left by the removed card
                  for (int i = 0; i < MAX_CARDS - 1; i++) begin
                     if (i >= int'(cursor_q))
                        slot_d[i] = slot_q[i+1];
                  end
                  slot_d[MAX_CARDS-1] = '0;
                  count_d = last;
                  if (cursor_q == last && count_q > ONE)
                     cursor_d = cursor_q - ONE;
                  if (count_q == ONE)
                     empty_d = 1'b1;
               end else begin
                  illegal_d = 1'b1;
               end
            end else if (count_q != '0) begin
               if (nxt_only)
                  cursor_d = (cursor_q == last) ? '0 : cursor_q + ONE;
               else if (prv_only)
                  cursor_d = (cursor_q == '0) ? last : cursor_q - ONE;
            end
         end
         S_REQ: begin
            if (count_q == FULL) begin
               pend_d  = '0;
               state_d = S_IDLE;
            end else if (deck.deck_done) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (deck.deck_drawn) begin
               slot_d[count_q[IDX_W-1:0]] = deck.deck_card;
               count_d = count_q + ONE;
               pend_d  = pend_q - 3'd1;
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            state_d = (pend_q != 3'd0) ? S_REQ : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= S_IDLE;
         pend_q    <= '0;
         count_q   <= '0;
         cursor_q  <= '0;
         slot_q    <= '{default: '0};
         play_q    <= '0;
         insert_q  <= 1'b0;
         illegal_q <= 1'b0;
         empty_q   <= 1'b0;
         busy_q    <= 1'b0;
         draw_q    <= '0;
      end else begin
         state_q   <= state_d;
         pend_q    <= pend_d;
         count_q   <= count_d;
         cursor_q  <= cursor_d;
         slot_q    <= slot_d;
         play_q    <= play_d;
         insert_q  <= insert_d;
         illegal_q <= illegal_d;
         empty_q   <= empty_d;
         busy_q    <= (state_d != S_IDLE);
         draw_q    <= (state_d == S_WAIT) ? DRAW1 : 3'b000;
      end
   end

   assign deck.deck_draw = draw_q;
   assign o_insert       = insert_q;
   assign o_play_card    = play_q;
   assign o_illegal      = illegal_q;
   assign o_cursor_card  = (count_q == '0) ? 6'h00 : cur_card;
   assign o_count        = count_q;
   assign o_cursor       = cursor_q;
   assign o_busy         = busy_q;
   assign o_empty        = empty_q;

endmodule

// File: tb/tb_player_hand.sv
// Bench for player_hand: deck model, play scoreboard, vector
// table for cursor/play behaviour and fetch corner sequences.
module tb_player_hand;
   import uno_pkg::*;

   localparam int CW = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          deal, cnext, cprev, play;
   logic [2:0]    draw_req;
   logic [5:0]    top;
   logic          insert, illegal, busy, empty;
   logic [5:0]    pcard, ccard;
   logic [CW-1:0] count, cursor;

   player_hand_if dif ();

   player_hand dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .deck          (dif.master),
      .i_deal        (deal),
      .i_draw_req    (draw_req),
      .i_cursor_next (cnext),
      .i_cursor_prev (cprev),
      .i_play        (play),
      .i_top_card    (top),
      .o_insert      (insert),
      .o_play_card   (pcard),
      .o_illegal     (illegal),
      .o_cursor_card (ccard),
      .o_count       (count),
      .o_cursor      (cursor),
      .o_busy        (busy),
      .o_empty       (empty)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       ins;
      logic [5:0] card;
   } ev_t;

   typedef struct {
      logic [1:0] op;
      logic [5:0] top;
      int         cnt;
      int         cur;
      logic [5:0] cc;
      logic       ins;
      logic       ill;
      logic       emp;
      logic [5:0] pc;
   } vec_t;

   localparam logic [1:0] NX = 2'd0;
   localparam logic [1:0] PV = 2'd1;
   localparam logic [1:0] PL = 2'd2;
   localparam logic [1:0] BO = 2'd3;

   int         ncmp = 0;
   int         nbad = 0;
   int         nreq = 0;
   logic [2:0] prv_draw = 3'b000;
   logic [5:0] deck_src [$];
   ev_t        evq [$];
   vec_t       tv [22];
   logic [5:0] dl [7];
   logic [5:0] fh [16];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cmd(input logic d, input logic [2:0] dr,
                      input logic n, input logic p, input logic pl);
      @(posedge clk);
      #1;
      deal = d; draw_req = dr; cnext = n; cprev = p; play = pl;
      @(posedge clk);
      #1;
      deal = 0; draw_req = 0; cnext = 0; cprev = 0; play = 0;
   endtask

   task automatic wait_idle(input string nm);
      int k;
      k = 0;
      while (busy && k < 400) begin
         @(negedge clk);
         k++;
      end
      chk({nm, "_idle"}, busy, 0);
   endtask

   // deck: answers each fresh draw-one after two cycles
   initial begin
      dif.deck_drawn = 0;
      dif.deck_card  = 0;
      forever begin
         @(negedge clk);
         if (rst_n && dif.deck_draw == 3'b001) begin
            repeat (2) @(posedge clk);
            #1;
            dif.deck_card  = deck_src.size() ? deck_src.pop_front() : 6'h00;
            dif.deck_drawn = 1;
            @(posedge clk);
            #1;
            dif.deck_drawn = 0;
            dif.deck_card  = 0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (dif.deck_draw == 3'b001 && prv_draw != 3'b001)
            nreq++;
         prv_draw = dif.deck_draw;
      end
   end

   initial begin
      ev_t e;
      forever begin
         @(negedge clk);
         if (insert || illegal) begin
            if (evq.size() == 0) begin
               chk("sb_unexpected", {insert, illegal}, 2'b00);
            end else begin
               e = evq.pop_front();
               chk("sb_kind", {insert, illegal}, {e.ins, ~e.ins});
               if (e.ins)
                  chk("sb_card", pcard, e.card);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int k;
      dl = '{6'h01, 6'h12, 6'h23, 6'h34, 6'h05, 6'h1D, 6'h2E};
      tv[0]  = '{NX, 6'h12, 7, 1, 6'h12, 0, 0, 0, 6'h00};
      tv[1]  = '{NX, 6'h12, 7, 2, 6'h23, 0, 0, 0, 6'h00};
      tv[2]  = '{PL, 6'h12, 7, 2, 6'h23, 0, 1, 0, 6'h00};
      tv[3]  = '{NX, 6'h12, 7, 3, 6'h34, 0, 0, 0, 6'h00};
      tv[4]  = '{PL, 6'h12, 7, 3, 6'h34, 0, 1, 0, 6'h00};
      tv[5]  = '{NX, 6'h12, 7, 4, 6'h05, 0, 0, 0, 6'h00};
      tv[6]  = '{NX, 6'h12, 7, 5, 6'h1D, 0, 0, 0, 6'h00};
      tv[7]  = '{PL, 6'h12, 6, 5, 6'h2E, 1, 0, 0, 6'h1D};
      tv[8]  = '{PL, 6'h12, 5, 4, 6'h05, 1, 0, 0, 6'h2E};
      tv[9]  = '{PL, 6'h12, 5, 4, 6'h05, 0, 1, 0, 6'h00};
      tv[10] = '{PL, 6'h05, 4, 3, 6'h34, 1, 0, 0, 6'h05};
      tv[11] = '{PL, 6'h14, 3, 2, 6'h23, 1, 0, 0, 6'h34};
      tv[12] = '{NX, 6'h14, 3, 0, 6'h01, 0, 0, 0, 6'h00};
      tv[13] = '{PV, 6'h14, 3, 2, 6'h23, 0, 0, 0, 6'h00};
      tv[14] = '{BO, 6'h14, 3, 2, 6'h23, 0, 0, 0, 6'h00};
      tv[15] = '{PL, 6'h20, 2, 1, 6'h12, 1, 0, 0, 6'h23};
      tv[16] = '{PL, 6'h01, 2, 1, 6'h12, 0, 1, 0, 6'h00};
      tv[17] = '{PL, 6'h32, 1, 0, 6'h01, 1, 0, 0, 6'h12};
      tv[18] = '{NX, 6'h32, 1, 0, 6'h01, 0, 0, 0, 6'h00};
      tv[19] = '{PL, 6'h01, 0, 0, 6'h00, 1, 0, 1, 6'h01};
      tv[20] = '{PL, 6'h01, 0, 0, 6'h00, 0, 1, 1, 6'h00};
      tv[21] = '{NX, 6'h01, 0, 0, 6'h00, 0, 0, 1, 6'h00};
      for (int i = 0; i < 16; i++)
         fh[i] = {2'(i), 4'(15 - i)};

      deal = 0; draw_req = 0; cnext = 0; cprev = 0; play = 0;
      top = 6'h12;
      dif.deck_done = 1;
      #1 rst_n = 0;
      repeat (3) @(negedge clk);
      chk("rst_count", count, 0);
      chk("rst_cursor", cursor, 0);
      chk("rst_ccard", ccard, 0);
      chk("rst_busy", busy, 0);
      chk("rst_empty", empty, 0);
      chk("rst_draw", dif.deck_draw, 0);
      chk("rst_pulses", {insert, illegal, pcard}, 0);
      rst_n = 1;

      // deal, with commands dropped while busy
      foreach (dl[i]) deck_src.push_back(dl[i]);
      nreq = 0;
      cmd(1, 0, 0, 0, 0);
      chk("deal_busy", busy, 1);
      cmd(0, 3'b001, 1, 0, 1);
      wait_idle("deal");
      chk("deal_count", count, 7);
      chk("deal_reqs", nreq, 7);
      chk("deal_cursor", cursor, 0);
      for (int i = 0; i < 7; i++) begin
         chk($sformatf("deal_slot%0d", i), ccard, dl[i]);
         cmd(0, 0, 1, 0, 0);
         @(negedge clk);
      end
      chk("deal_wrap", cursor, 0);

      for (int i = 0; i < 22; i++) begin
         top = tv[i].top;
         if (tv[i].ins || tv[i].ill)
            evq.push_back('{tv[i].ins, tv[i].pc});
         cmd(0, 0, tv[i].op == NX || tv[i].op == BO,
             tv[i].op == PV || tv[i].op == BO, tv[i].op == PL);
         @(negedge clk);
         chk($sformatf("tv%0d_count", i), count, tv[i].cnt);
         chk($sformatf("tv%0d_cursor", i), cursor, tv[i].cur);
         chk($sformatf("tv%0d_ccard", i), ccard, tv[i].cc);
         chk($sformatf("tv%0d_empty", i), empty, tv[i].emp);
         #1;
         chk($sformatf("tv%0d_sbq", i), evq.size(), 0);
      end

      // refill to a full hand
      foreach (fh[i]) deck_src.push_back(fh[i]);
      cmd(1, 0, 0, 0, 0);
      @(negedge clk);
      chk("fh_empty_clr", empty, 0);
      wait_idle("fh_deal");
      chk("fh_deal_cnt", count, 7);
      nreq = 0;
      cmd(0, 3'b011, 0, 0, 0);
      repeat (6) @(negedge clk);
      chk("nonhot_busy", busy, 0);
      chk("nonhot_reqs", nreq, 0);
      chk("nonhot_cnt", count, 7);
      dif.deck_done = 0;
      cmd(0, 3'b010, 0, 0, 0);
      repeat (4) @(negedge clk);
      chk("notdone_draw", dif.deck_draw, 0);
      chk("notdone_busy", busy, 1);
      dif.deck_done = 1;
      wait_idle("draw2");
      chk("draw2_cnt", count, 9);
      chk("draw2_reqs", nreq, 2);
      cmd(0, 3'b100, 0, 0, 0);
      wait_idle("draw4a");
      chk("draw4a_cnt", count, 13);
      cmd(0, 3'b010, 0, 0, 0);
      wait_idle("draw2b");
      chk("draw2b_cnt", count, 15);
      nreq = 0;
      cmd(0, 3'b100, 0, 0, 0);
      wait_idle("full");
      repeat (4) @(negedge clk);
      chk("full_cnt", count, 16);
      chk("full_reqs", nreq, 1);
      chk("full_busy", busy, 0);
      cmd(0, 3'b001, 0, 0, 0);
      wait_idle("full_again");
      repeat (4) @(negedge clk);
      chk("full_again_cnt", count, 16);
      chk("full_again_reqs", nreq, 1);
      chk("full_slot0", ccard, fh[0]);
      cmd(0, 0, 0, 1, 0);
      @(negedge clk);
      chk("full_prev_cur", cursor, 15);
      chk("full_slot15", ccard, fh[15]);

      // reset in the middle of a fetch
      deck_src.delete();
      foreach (dl[i]) deck_src.push_back(dl[i]);
      nreq = 0;
      cmd(1, 0, 0, 0, 0);
      k = 0;
      while (!(nreq >= 3 && dif.deck_draw == 3'b001) && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("mid_reached", (nreq >= 3 && dif.deck_draw == 3'b001), 1);
      chk("mid_count", count, 2);
      #2 rst_n = 0;
      #1;
      chk("mrst_draw", dif.deck_draw, 0);
      chk("mrst_count", count, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_cursor", cursor, 0);
      chk("mrst_ccard", ccard, 0);
      chk("mrst_outs", {insert, illegal, empty, pcard}, 0);
      repeat (4) @(negedge clk);
      rst_n = 1;
      nreq = 0;
      repeat (10) @(negedge clk);
      chk("post_rst_reqs", nreq, 0);
      chk("post_rst_count", count, 0);
      chk("post_rst_busy", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
      $finish;
   end

endmodule
